// File: rtl/mem_stack_if.sv
// mem_stack_if: bus bundle between the fetch/execute units and mem_stack.
// Read ports, byte-enabled write port, stack requests and stack results.
// master = requesting side (core / testbench), slave = mem_stack.
interface mem_stack_if #(
   parameter int AW  = 16,
   parameter int NRD = 2
);
   logic [NRD*AW-1:0] raddr;      // port k address = raddr[k*AW +: AW]
   logic [NRD*16-1:0] rdata;      // port k word    = rdata[k*16 +: 16]
   logic              wen;
   logic [AW-1:0]     waddr;
   logic [15:0]       wdata;
   logic [1:0]        wbe;
   logic              push;
   logic              pop;
   logic              swap;
   logic [15:0]       push_data;
   logic              sp_load;
   logic [AW-1:0]     sp_wdata;
   logic [AW-1:0]     sp;
   logic              busy;
   logic              pop_valid;
   logic [15:0]       pop_data;

   modport master (
      output raddr, wen, waddr, wdata, wbe,
      output push, pop, swap, push_data, sp_load, sp_wdata,
      input  rdata, sp, busy, pop_valid, pop_data
   );

   modport slave (
      input  raddr, wen, waddr, wdata, wbe,
      input  push, pop, swap, push_data, sp_load, sp_wdata,
      output rdata, sp, busy, pop_valid, pop_data
   );
endinterface

// File: rtl/mem_stack.sv
// mem_stack: 2^AW-byte main memory, NRD word read ports, byte-enabled write port, SP stack engine.
// Latency: reads 2 edges (address registered, then array read); pop data 2 edges; swap result 1 edge after accept.
// Backpressure: none on reads/writes; stack requests are dropped while busy (swap in flight).
// Ports: clk, rst_n (async, active low), bus (mem_stack_if.slave): raddr/rdata read ports,
//        wen/waddr/wdata/wbe write port, push/pop/swap/push_data/sp_load/sp_wdata requests,
//        sp/busy/pop_valid/pop_data status. INIT_FILE names the preload image for simulation
//        harnesses; the array itself has no reset and no built-in preload.
module mem_stack #(
   parameter int          AW        = 16,
   parameter int          NRD       = 2,
   parameter logic [15:0] SP_RESET  = 16'hFFFF,
   parameter              INIT_FILE = "mem.hex"
) (
   input  logic       clk,
   input  logic       rst_n,
   mem_stack_if.slave bus
);

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_SWAP_RD = 1'b1;

   logic [7:0]        mem [0:(1<<AW)-1];

   logic [0:0]        state;
   logic [AW-1:0]     sp_q;
   logic [AW-1:0]     stk_addr_q;   // word address for the pending pop read or swap
   logic [15:0]       swap_dat_q;
   logic              pop_pend_q;
   logic [NRD*AW-1:0] raddr_q;
   logic [NRD*16-1:0] rdata_q;
   logic              pop_valid_q;
   logic [15:0]       pop_data_q;

   logic              idle;
   logic              acc_load;
   logic              acc_swap;
   logic              acc_pop;
   logic              acc_push;
   logic [AW-1:0]     sp_m1;
   logic [AW-1:0]     sp_m2;
   logic [AW-1:0]     sp_p2;

   // Little-endian word read; a+1 wraps at the top of the address space.
   function automatic logic [15:0] rd_word(input logic [AW-1:0] a);
      return {mem[a + AW'(1)], mem[a]};
   endfunction

   // One stack request per cycle: sp_load > swap > pop > push; losers are dropped.
   assign idle     = (state == S_IDLE);
   assign acc_load = idle & bus.sp_load;
   assign acc_swap = idle & bus.swap & ~bus.sp_load;
   assign acc_pop  = idle & bus.pop  & ~bus.swap & ~bus.sp_load;
   assign acc_push = idle & bus.push & ~bus.pop  & ~bus.swap & ~bus.sp_load;

   assign sp_m1 = sp_q - AW'(1);
   assign sp_m2 = sp_q - AW'(2);
   assign sp_p2 = sp_q + AW'(2);

   // Array writes. Stack writes come last so they win any byte collision with
   // the external port; non-overlapping external bytes still commit.
   always_ff @(posedge clk) begin
      if (bus.wen && bus.wbe[0]) mem[bus.waddr]          <= bus.wdata[7:0];
      if (bus.wen && bus.wbe[1]) mem[bus.waddr + AW'(1)] <= bus.wdata[15:8];
      if (acc_push) begin
         mem[sp_m1] <= bus.push_data[15:8];
         mem[sp_m2] <= bus.push_data[7:0];
      end
      if (state == S_SWAP_RD) begin
         mem[stk_addr_q]          <= swap_dat_q[7:0];
         mem[stk_addr_q + AW'(1)] <= swap_dat_q[15:8];
      end
   end

   // Read ports: address captured first, array sampled on the following edge,
   // so a write on the capture edge is visible and one on the read edge is not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raddr_q <= '0;
         rdata_q <= '0;
      end else begin
         raddr_q <= bus.raddr;
         for (int k = 0; k < NRD; k++) begin
            rdata_q[k*16 +: 16] <= rd_word(raddr_q[k*AW +: AW]);
         end
      end
   end

   // Stack engine. A pop and a swap both read through stk_addr_q one edge after
   // acceptance; they can never be due on the same edge because only one
   // request is accepted per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         sp_q        <= SP_RESET[AW-1:0];
         stk_addr_q  <= '0;
         swap_dat_q  <= '0;
         pop_pend_q  <= 1'b0;
         pop_valid_q <= 1'b0;
         pop_data_q  <= '0;
      end else begin
         pop_pend_q  <= acc_pop;
         pop_valid_q <= 1'b0;

         if (acc_load)      sp_q <= bus.sp_wdata;
         else if (acc_pop)  sp_q <= sp_p2;
         else if (acc_push) sp_q <= sp_m2;

         if (acc_pop || acc_swap) stk_addr_q <= sp_q;
         if (acc_swap)            swap_dat_q <= bus.push_data;

         // SWAP_RD always lasts exactly one cycle; acc_swap is 0 there.
         state <= acc_swap ? S_SWAP_RD : S_IDLE;

         if (pop_pend_q || (state == S_SWAP_RD)) begin
            pop_valid_q <= 1'b1;
            pop_data_q  <= rd_word(stk_addr_q);
         end
      end
   end

   assign bus.rdata     = rdata_q;
   assign bus.sp        = sp_q;
   assign bus.busy      = (state == S_SWAP_RD);
   assign bus.pop_valid = pop_valid_q;
   assign bus.pop_data  = pop_data_q;

endmodule

// File: tb/tb_mem_stack.sv
// tb_mem_stack: directed, table-driven bench for mem_stack (AW=16, NRD=2).
// Each table row is driven for one clock; outputs are sampled 1 time unit after that edge.
// Hand-written sequences cover reset values and reset in the middle of a swap.
module tb_mem_stack;

   localparam logic T = 1'b1;
   localparam logic F = 1'b0;
   localparam int   NV = 36;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_stack_if #(.AW(16), .NRD(2)) bus ();

   mem_stack #(
      .AW(16), .NRD(2), .SP_RESET(16'hFFFF), .INIT_FILE("")
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // op = {sp_load, swap, pop, push}; d feeds both push_data and sp_wdata.
   // Expectations describe the outputs right after the row's clock edge.
   typedef struct {
      logic        wen;
      logic [15:0] waddr;
      logic [15:0] wdata;
      logic [1:0]  wbe;
      logic [3:0]  op;
      logic [15:0] d;
      logic [15:0] ra0;
      logic [15:0] ra1;
      logic [15:0] e_sp;
      logic        e_busy;
      logic        e_pv;
      logic [15:0] e_pd;
      logic        c_pd;
      logic        c0;
      logic [15:0] e_rd0;
      logic        c1;
      logic [15:0] e_rd1;
   } vec_t;

   vec_t vt [NV];
   vec_t iv;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.wen       = v.wen;
      bus.waddr     = v.waddr;
      bus.wdata     = v.wdata;
      bus.wbe       = v.wbe;
      {bus.sp_load, bus.swap, bus.pop, bus.push} = v.op;
      bus.push_data = v.d;
      bus.sp_wdata  = v.d;
      bus.raddr     = {v.ra1, v.ra0};
   endtask

   initial begin
      //          wen waddr     wdata     wbe    op      d          ra0       ra1        e_sp      bsy pv e_pd     cpd  c0 e_rd0     c1 e_rd1
      // external write/read, byte enables, wrap, no-op writes
      vt[ 0] = '{T,16'h1000,16'h5A11,2'b11, 4'b0000,16'h0000, 16'h1000,16'hFFFF, 16'hFFFF,F,F,16'h0000,F, F,16'h0000,F,16'h0000};
      vt[ 1] = '{T,16'h1000,16'hBEEF,2'b01, 4'b0000,16'h0000, 16'h1000,16'h1000, 16'hFFFF,F,F,16'h0000,F, T,16'h5A11,F,16'h0000};
      vt[ 2] = '{T,16'h1000,16'hBEEF,2'b11, 4'b0000,16'h0000, 16'h1000,16'h1001, 16'hFFFF,F,F,16'h0000,F, T,16'h5AEF,T,16'h5AEF};
      vt[ 3] = '{T,16'hFFFF,16'h1234,2'b11, 4'b0000,16'h0000, 16'h1000,16'hFFFF, 16'hFFFF,F,F,16'h0000,F, T,16'hBEEF,F,16'h0000};
      vt[ 4] = '{F,16'h1000,16'h0000,2'b11, 4'b0000,16'h0000, 16'hFFFF,16'h0000, 16'hFFFF,F,F,16'h0000,F, T,16'hBEEF,T,16'h1234};
      vt[ 5] = '{T,16'h1000,16'h0000,2'b00, 4'b0000,16'h0000, 16'h1000,16'hFFFF, 16'hFFFF,F,F,16'h0000,F, T,16'h1234,F,16'h0000};
      vt[ 6] = '{F,16'h0000,16'h0000,2'b00, 4'b0000,16'h0000, 16'h1000,16'hFFFF, 16'hFFFF,F,F,16'h0000,F, T,16'hBEEF,T,16'h1234};
      // sp_load, back-to-back push, back-to-back pop
      vt[ 7] = '{F,16'h0000,16'h0000,2'b00, 4'b1000,16'h2000, 16'h1000,16'hFFFF, 16'h2000,F,F,16'h0000,F, T,16'hBEEF,T,16'h1234};
      vt[ 8] = '{F,16'h0000,16'h0000,2'b00, 4'b0001,16'hAAAA, 16'h1FFE,16'hFFFF, 16'h1FFE,F,F,16'h0000,F, T,16'hBEEF,T,16'h1234};
      vt[ 9] = '{F,16'h0000,16'h0000,2'b00, 4'b0001,16'hBBBB, 16'h1FFC,16'hFFFF, 16'h1FFC,F,F,16'h0000,F, T,16'hAAAA,T,16'h1234};
      vt[10] = '{F,16'h0000,16'h0000,2'b00, 4'b0010,16'h0000, 16'h1FFC,16'hFFFF, 16'h1FFE,F,F,16'h0000,F, T,16'hBBBB,T,16'h1234};
      vt[11] = '{F,16'h0000,16'h0000,2'b00, 4'b0010,16'h0000, 16'h1FFC,16'hFFFF, 16'h2000,F,T,16'hBBBB,T, T,16'hBBBB,T,16'h1234};
      vt[12] = '{F,16'h0000,16'h0000,2'b00, 4'b0000,16'h0000, 16'h1FFC,16'hFFFF, 16'h2000,F,T,16'hAAAA,T, T,16'hBBBB,T,16'h1234};
      vt[13] = '{F,16'h0000,16'h0000,2'b00, 4'b0000,16'h0000, 16'h1FFC,16'hFFFF, 16'h2000,F,F,16'h0000,F, T,16'hBBBB,T,16'h1234};
      // swap with a pop issued while busy
      vt[14] = '{F,16'h0000,16'h0000,2'b00, 4'b0001,16'h1111, 16'h1FFE,16'hFFFF, 16'h1FFE,F,F,16'h0000,F, T,16'hBBBB,T,16'h1234};
      vt[15] = '{F,16'h0000,16'h0000,2'b00, 4'b0100,16'h2222, 16'h1FFE,16'hFFFF, 16'h1FFE,T,F,16'h0000,F, T,16'h1111,T,16'h1234};
      vt[16] = '{F,16'h0000,16'h0000,2'b00, 4'b0010,16'h0000, 16'h1FFE,16'hFFFF, 16'h1FFE,F,T,16'h1111,T, T,16'h1111,T,16'h1234};
      vt[17] = '{F,16'h0000,16'h0000,2'b00, 4'b0000,16'h0000, 16'h1FFE,16'hFFFF, 16'h1FFE,F,F,16'h0000,F, T,16'h2222,T,16'h1234};
      vt[18] = '{F,16'h0000,16'h0000,2'b00, 4'b0010,16'h0000, 16'h1FFE,16'hFFFF, 16'h2000,F,F,16'h0000,F, T,16'h2222,T,16'h1234};
      vt[19] = '{F,16'h0000,16'h0000,2'b00, 4'b0000,16'h0000, 16'h1FFE,16'hFFFF, 16'h2000,F,T,16'h2222,T, T,16'h2222,T,16'h1234};
      // push then pop on the next cycle returns the pushed word
      vt[20] = '{F,16'h0000,16'h0000,2'b00, 4'b0001,16'hC3A5, 16'h1FFE,16'hFFFF, 16'h1FFE,F,F,16'h0000,F, T,16'h2222,T,16'h1234};
      vt[21] = '{F,16'h0000,16'h0000,2'b00, 4'b0010,16'h0000, 16'h1FFE,16'hFFFF, 16'h2000,F,F,16'h0000,F, T,16'hC3A5,T,16'h1234};
      vt[22] = '{F,16'h0000,16'h0000,2'b00, 4'b0000,16'h0000, 16'h1FFE,16'h1FFF, 16'h2000,F,T,16'hC3A5,T, T,16'hC3A5,T,16'h1234};
      // push/wen collision on byte 1FFF; push+pop; sp_load+push; swap+pop
      vt[23] = '{T,16'h1FFF,16'h7766,2'b11, 4'b0001,16'h9988, 16'h1FFE,16'h1FFF, 16'h1FFE,F,F,16'h0000,F, T,16'hC3A5,F,16'h0000};
      vt[24] = '{F,16'h0000,16'h0000,2'b00, 4'b0000,16'h0000, 16'h1FFE,16'h1FFF, 16'h1FFE,F,F,16'h0000,F, T,16'h9988,T,16'h7799};
      vt[25] = '{F,16'h0000,16'h0000,2'b00, 4'b0011,16'h5555, 16'h1FFE,16'h1FFF, 16'h2000,F,F,16'h0000,F, T,16'h9988,T,16'h7799};
      vt[26] = '{F,16'h0000,16'h0000,2'b00, 4'b0000,16'h0000, 16'h1FFE,16'h1FFF, 16'h2000,F,T,16'h9988,T, T,16'h9988,T,16'h7799};
      vt[27] = '{F,16'h0000,16'h0000,2'b00, 4'b1001,16'h3000, 16'h3000,16'h1FFF, 16'h3000,F,F,16'h0000,F, T,16'h9988,T,16'h7799};
      vt[28] = '{F,16'h0000,16'h0000,2'b00, 4'b0110,16'h4444, 16'h3000,16'h1FFF, 16'h3000,T,F,16'h0000,F, F,16'h0000,T,16'h7799};
      vt[29] = '{F,16'h0000,16'h0000,2'b00, 4'b0000,16'h0000, 16'h3000,16'h1FFF, 16'h3000,F,T,16'h0000,F, F,16'h0000,T,16'h7799};
      vt[30] = '{F,16'h0000,16'h0000,2'b00, 4'b0000,16'h0000, 16'h3000,16'h1FFF, 16'h3000,F,F,16'h0000,F, T,16'h4444,T,16'h7799};
      // swaps held high: one accepted every 2 cycles
      vt[31] = '{F,16'h0000,16'h0000,2'b00, 4'b0100,16'h6666, 16'h3000,16'h1FFF, 16'h3000,T,F,16'h0000,F, T,16'h4444,T,16'h7799};
      vt[32] = '{F,16'h0000,16'h0000,2'b00, 4'b0100,16'h7777, 16'h3000,16'h1FFF, 16'h3000,F,T,16'h4444,T, T,16'h4444,T,16'h7799};
      vt[33] = '{F,16'h0000,16'h0000,2'b00, 4'b0100,16'h7777, 16'h3000,16'h1FFF, 16'h3000,T,F,16'h0000,F, T,16'h6666,T,16'h7799};
      vt[34] = '{F,16'h0000,16'h0000,2'b00, 4'b0000,16'h0000, 16'h3000,16'h1FFF, 16'h3000,F,T,16'h6666,T, T,16'h6666,T,16'h7799};
      vt[35] = '{F,16'h0000,16'h0000,2'b00, 4'b0000,16'h0000, 16'h3000,16'h1FFF, 16'h3000,F,F,16'h0000,F, T,16'h7777,T,16'h7799};

      iv = '{default: '0};
      drive(iv);

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst sp",        bus.sp, 16'hFFFF);
      chk("rst busy",      16'(bus.busy), 16'h0000);
      chk("rst pop_valid", 16'(bus.pop_valid), 16'h0000);
      chk("rst pop_data",  bus.pop_data, 16'h0000);
      chk("rst rdata0",    bus.rdata[15:0], 16'h0000);
      chk("rst rdata1",    bus.rdata[31:16], 16'h0000);

      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vt[i]);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d sp", i), bus.sp, vt[i].e_sp);
         chk($sformatf("v%0d busy", i), 16'(bus.busy), 16'(vt[i].e_busy));
         chk($sformatf("v%0d pop_valid", i), 16'(bus.pop_valid), 16'(vt[i].e_pv));
         if (vt[i].c_pd) chk($sformatf("v%0d pop_data", i), bus.pop_data, vt[i].e_pd);
         if (vt[i].c0)   chk($sformatf("v%0d rdata0", i), bus.rdata[15:0], vt[i].e_rd0);
         if (vt[i].c1)   chk($sformatf("v%0d rdata1", i), bus.rdata[31:16], vt[i].e_rd1);
      end

      // Reset while in SWAP_RD: the swap write to 3000 must be discarded.
      iv.ra0 = 16'h3000;
      iv.ra1 = 16'h1FFF;
      iv.op  = 4'b0100;
      iv.d   = 16'h5555;
      @(negedge clk);
      drive(iv);
      @(posedge clk);
      #1;
      chk("midrst busy before", 16'(bus.busy), 16'h0001);
      @(negedge clk);
      iv.op = 4'b0000;
      iv.d  = 16'h0000;
      drive(iv);
      rst_n = 1'b0;
      #1;
      chk("midrst busy",      16'(bus.busy), 16'h0000);
      chk("midrst pop_valid", 16'(bus.pop_valid), 16'h0000);
      chk("midrst sp",        bus.sp, 16'hFFFF);
      chk("midrst rdata0",    bus.rdata[15:0], 16'h0000);
      @(posedge clk);
      #1;
      chk("midrst pop_valid held", 16'(bus.pop_valid), 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("postrst pop_valid", 16'(bus.pop_valid), 16'h0000);
      @(posedge clk);
      #1;
      chk("postrst rdata0 no swap write", bus.rdata[15:0], 16'h7777);
      chk("postrst pop_valid 2", 16'(bus.pop_valid), 16'h0000);
      chk("postrst sp", bus.sp, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
